imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the LEGv8 decode stage. It accepts one 32-bit instruction word per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate, a format code and an illegal flag one cycle later. It covers D, CB, B, I and IW (MOVZ with halfword shift) formats and supports optional branch-offset scaling. A skid buffer isolates decode backpressure from fetch, and a saturating counter tracks unrecognised encodings.

## Interface
- `N`, 64: immediate/output width; legal range 32..64.
- `BR_SCALE`, 0: when 1, CB- and B-format immediates are shifted left by 2 after extension.
- `CNT_W`, 16: width of the illegal-instruction counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `instr`  in  32  instruction word.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result this cycle.
- `imm`  out  N  extended immediate.
- `fmt`  out  3  0=ILL, 1=D, 2=CB, 3=B, 4=I, 5=IW.
- `illegal`  out  1  encoding not recognised (`fmt`=0).
- `illegal_cnt`  out  CNT_W  saturating count of accepted illegal words.

## Operation
- Decode is combinational on `instr`, with the first match taken in this order:
  - `instr[31:21]` = 11111000010 (LDUR) or 11111000000 (STUR): D; `imm` = sext(`instr[20:12]`).
  - `instr[31:24]` = 10110100 (CBZ), 10110101 (CBNZ) or 01010100 (B.cond): CB; `imm` = sext(`instr[23:5]`).
  - `instr[31:26]` = 000101 (B) or 100101 (BL): B; `imm` = sext(`instr[25:0]`).
  - `instr[31:22]` = 1001000100 (ADDI) or 1101000100 (SUBI): I; `imm` = zext(`instr[21:10]`).
  - `instr[31:23]` = 110100101 (MOVZ): IW; `imm` = zext(`instr[20:5]`) << (16 × `instr[22:21]`). The result is truncated to N bits, so for N=32 with hw≥2 it is 0.
  - Otherwise: ILL; `imm` = 0, `illegal` = 1.
- Scaling: if `BR_SCALE`=1, CB and B results are shifted left by 2 and truncated to N. Scaling is applied after extension.
- Storage: one output register (OR) plus one skid register (SR), each holding {imm, fmt, illegal} and a valid bit.
- States: EMPTY (OR invalid), ONE (OR valid, SR invalid), FULL (both valid).
- `in_ready` = !SR.valid, driven from a register (no combinational path from `out_ready`).
- Accept: `in_valid && in_ready`.
  - EMPTY + accept → ONE.
  - ONE + accept + `out_ready` → ONE (OR reloaded).
  - ONE + accept + !`out_ready` → FULL (word goes to SR).
  - ONE + no accept + `out_ready` → EMPTY.
  - FULL + `out_ready` → ONE (OR ← SR, SR cleared). No accept is possible in FULL.
  - FULL + !`out_ready` → FULL (hold).
- Outputs `imm`, `fmt`, `illegal` come straight from OR and must be stable while `out_valid && !out_ready`.
- `illegal_cnt` increments by 1 on each accepted ILL word and saturates at 2^CNT_W−1. It counts at acceptance, not emission.
- Reset (asynchronous, any time, including mid-transfer): OR and SR are invalidated and in-flight words dropped. `out_valid`=0, `in_ready`=1, `imm`=0, `fmt`=0, `illegal`=0, `illegal_cnt`=0. Operation resumes on the first rising edge after `reset_n` deasserts.

## Timing
- Latency: a word accepted at edge k appears with `out_valid`=1 after edge k.
- Throughput: 1 word/cycle while `out_ready`=1.
- On the first stall cycle, one additional word is absorbed into SR. `in_ready` falls after that edge.
- `in_ready` rises one cycle after SR drains.
- No data loss or duplication under any `in_valid`/`out_ready` pattern.
- Simultaneous accept and emit in ONE is legal and sustains full rate.

## Test plan
- Reset, then LDUR `instr`=0xF85F8041 → next cycle `out_valid`=1, `imm`=0xFFFF_FFFF_FFFF_FFF8, `fmt`=1, `illegal`=0.
- MOVZ `instr`=0xD2A24680 (hw=1, imm16=0x1234) → `imm`=0x0000_0000_1234_0000, `fmt`=5. With N=32 and hw=2 (0xD2C24680) → `imm`=0.
- CBZ 0xB4FFFFE0 → `imm`=all ones, `fmt`=2. With BR_SCALE=1 → 0xFFFF_FFFF_FFFF_FFFC. B 0x16000000 → 0xFFFF_FFFF_FE00_0000, `fmt`=3.
- `instr`=0x00000000 three times → `imm`=0, `illegal`=1, `fmt`=0 each time, `illegal_cnt`=3. With CNT_W=2 and 5 illegal words → `illegal_cnt`=3 (saturated).
- Stream 8 distinct words with `out_ready` toggling randomly and held low for 4 cycles:
  - `in_ready` drops after exactly 2 words are buffered.
  - The output sequence matches the input order exactly.
  - `imm` is stable during the stall.
- Assert `reset_n`=0 in FULL state mid-stream → `out_valid`=0 and `in_ready`=1 immediately. After release, a new word emerges with 1-cycle latency and no stale data.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with a valid/ready output stage and skid buffer.
// Decodes D/CB/B/I/IW formats, optionally scales branch offsets, counts illegal words.
module imm_gen_pipe #(
    parameter int N        = 64,
    parameter int BR_SCALE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_ILL = 3'd0,
        FMT_D   = 3'd1,
        FMT_CB  = 3'd2,
        FMT_B   = 3'd3,
        FMT_I   = 3'd4,
        FMT_IW  = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    logic [N-1:0]     dec_imm;
    fmt_e             dec_fmt;
    logic             dec_ill;
    logic             accept;
    logic [CNT_W-1:0] cnt_d;

    state_e           state_q;
    logic             in_ready_q;
    logic [N-1:0]     or_imm_q, sr_imm_q;
    fmt_e             or_fmt_q, sr_fmt_q;
    logic             or_ill_q, sr_ill_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
            dec_fmt = FMT_D;
            dec_imm = {{(N-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5 ||
                     instr[31:24] == 8'h54) begin
            dec_fmt = FMT_CB;
            dec_imm = {{(N-19){instr[23]}}, instr[23:5]};
        end else if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
            dec_fmt = FMT_B;
            dec_imm = {{(N-26){instr[25]}}, instr[25:0]};
        end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
            dec_fmt = FMT_I;
            dec_imm = N'(instr[21:10]);
        end else if (instr[31:23] == 9'b110100101) begin
            dec_fmt = FMT_IW;
            // Shifts of N or more bits (N=32, hw>=2) yield zero.
            dec_imm = N'(instr[20:5]) << {instr[22:21], 4'b0000};
        end
        if (BR_SCALE != 0 && (dec_fmt == FMT_CB || dec_fmt == FMT_B)) begin
            dec_imm = dec_imm << 2;
        end
    end

    assign dec_ill = (dec_fmt == FMT_ILL);
    assign accept  = in_valid && in_ready_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec_ill && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            or_imm_q   <= '0;
            or_fmt_q   <= FMT_ILL;
            or_ill_q   <= 1'b0;
            sr_imm_q   <= '0;
            sr_fmt_q   <= FMT_ILL;
            sr_ill_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        or_imm_q <= dec_imm;
                        or_fmt_q <= dec_fmt;
                        or_ill_q <= dec_ill;
                        state_q  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        or_imm_q <= dec_imm;
                        or_fmt_q <= dec_fmt;
                        or_ill_q <= dec_ill;
                    end else if (accept) begin
                        // Consumer stalled: park the new word so fetch never sees out_ready.
                        sr_imm_q   <= dec_imm;
                        sr_fmt_q   <= dec_fmt;
                        sr_ill_q   <= dec_ill;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        or_imm_q   <= sr_imm_q;
                        or_fmt_q   <= sr_fmt_q;
                        or_ill_q   <= sr_ill_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign imm         = or_imm_q;
    assign fmt         = or_fmt_q;
    assign illegal     = or_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: default instance (N=64) and a narrow one
// (N=32, BR_SCALE=1, CNT_W=2) share stimulus; each has its own expected queue.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] e64;
        logic [31:0] e32;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready1, out_valid1, illegal1;
    logic [63:0] imm1;
    logic [2:0]  fmt1;
    logic [15:0] cnt1;

    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] imm2;
    logic [2:0]  fmt2;
    logic [1:0]  cnt2;

    int passed = 0;
    int total  = 0;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vt [0:11];
    vec_t vill;

    logic        stall_prev = 1'b0;
    logic [63:0] prev_imm;
    logic [2:0]  prev_fmt;

    imm_gen_pipe #(.N(64), .BR_SCALE(0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .instr(instr), .out_valid(out_valid1), .out_ready(out_ready),
        .imm(imm1), .fmt(fmt1), .illegal(illegal1), .illegal_cnt(cnt1)
    );

    imm_gen_pipe #(.N(32), .BR_SCALE(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .instr(instr), .out_valid(out_valid2), .out_ready(out_ready),
        .imm(imm2), .fmt(fmt2), .illegal(illegal2), .illegal_cnt(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic push(input vec_t v);
        q1.push_back('{v.e64, v.fmt, v.ill});
        q2.push_back('{64'(v.e32), v.fmt, v.ill});
    endtask

    // Drive at posedge+1, decide acceptance at the negedge, return at next posedge+1.
    task automatic cycle(input logic v, input vec_t w, input logic rdy, output logic acc);
        in_valid  = v;
        instr     = w.instr;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready1;
        if (acc) push(w);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 50; i++) begin
            if (!out_valid1 && !out_valid2 && q1.size() == 0 && q2.size() == 0) break;
            cycle(1'b0, vt[0], 1'b1, acc);
        end
        chk("drain_q1_empty", 64'(q1.size()), 64'd0);
        chk("drain_q2_empty", 64'(q2.size()), 64'd0);
    endtask

    always @(negedge reset_n) stall_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL sb1_unexpected: got imm %h with no expected entry", imm1);
            end else begin
                e = q1.pop_front();
                chk("sb1_imm", imm1, e.imm);
                chk("sb1_fmt", 64'(fmt1), 64'(e.fmt));
                chk("sb1_illegal", 64'(illegal1), 64'(e.ill));
            end
        end
        if (reset_n && out_valid2 && out_ready) begin
            if (q2.size() == 0) begin
                total++;
                $display("FAIL sb2_unexpected: got imm %h with no expected entry", imm2);
            end else begin
                e = q2.pop_front();
                chk("sb2_imm", 64'(imm2), e.imm);
                chk("sb2_fmt", 64'(fmt2), 64'(e.fmt));
                chk("sb2_illegal", 64'(illegal2), 64'(e.ill));
            end
        end
        if (stall_prev && reset_n) begin
            chk("stall_valid_held", 64'(out_valid1), 64'd1);
            chk("stall_imm_stable", imm1, prev_imm);
            chk("stall_fmt_stable", 64'(fmt1), 64'(prev_fmt));
        end
        stall_prev = reset_n && out_valid1 && !out_ready;
        prev_imm   = imm1;
        prev_fmt   = fmt1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   k;
        int   cyc;
        logic rdy;

        vt[0]  = '{32'hF85F8041, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd1, 1'b0};
        vt[1]  = '{32'hD2A24680, 64'h0000_0000_1234_0000, 32'h1234_0000, 3'd5, 1'b0};
        vt[2]  = '{32'hD2C24680, 64'h0000_1234_0000_0000, 32'h0000_0000, 3'd5, 1'b0};
        vt[3]  = '{32'hD2E24680, 64'h1234_0000_0000_0000, 32'h0000_0000, 3'd5, 1'b0};
        vt[4]  = '{32'hB4FFFFE0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFC, 3'd2, 1'b0};
        vt[5]  = '{32'h16000000, 64'hFFFF_FFFF_FE00_0000, 32'hF800_0000, 3'd3, 1'b0};
        vt[6]  = '{32'h913FFC00, 64'h0000_0000_0000_0FFF, 32'h0000_0FFF, 3'd4, 1'b0};
        vt[7]  = '{32'hD1200000, 64'h0000_0000_0000_0800, 32'h0000_0800, 3'd4, 1'b0};
        vt[8]  = '{32'hF80FF000, 64'h0000_0000_0000_00FF, 32'h0000_00FF, 3'd1, 1'b0};
        vt[9]  = '{32'hB5000020, 64'h0000_0000_0000_0001, 32'h0000_0004, 3'd2, 1'b0};
        vt[10] = '{32'h54000040, 64'h0000_0000_0000_0002, 32'h0000_0008, 3'd2, 1'b0};
        vt[11] = '{32'h94000003, 64'h0000_0000_0000_0003, 32'h0000_000C, 3'd3, 1'b0};
        vill   = '{32'h00000000, 64'd0, 32'd0, 3'd0, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid1), 64'd0);
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        chk("rst_imm", imm1, 64'd0);
        chk("rst_fmt", 64'(fmt1), 64'd0);
        chk("rst_illegal", 64'(illegal1), 64'd0);
        chk("rst_cnt", 64'(cnt1), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back decode of every format at full rate.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vt[i], 1'b1, acc);
            chk("fullrate_accept", 64'(acc), 64'd1);
            if (i == 0) chk("latency_out_valid", 64'(out_valid1), 64'd1);
        end
        drain();

        for (int i = 0; i < 3; i++) cycle(1'b1, vill, 1'b1, acc);
        chk("cnt1_after3", 64'(cnt1), 64'd3);
        chk("cnt2_after3", 64'(cnt2), 64'd3);
        for (int i = 0; i < 2; i++) cycle(1'b1, vill, 1'b1, acc);
        chk("cnt1_after5", 64'(cnt1), 64'd5);
        chk("cnt2_saturated", 64'(cnt2), 64'd3);
        drain();

        // Stream 8 words: 4 stalled cycles first, then random out_ready.
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            rdy = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            cycle(1'b1, vt[k], rdy, acc);
            if (cyc < 4) chk("skid_accept_pattern", 64'(acc), (cyc < 2) ? 64'd1 : 64'd0);
            if (acc) k++;
            cyc++;
        end
        chk("stream_all_accepted", 64'(k), 64'd8);
        drain();

        // Reset while FULL drops both buffered words.
        cycle(1'b1, vt[9], 1'b0, acc);
        cycle(1'b1, vt[10], 1'b0, acc);
        chk("full_in_ready_low", 64'(in_ready1), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid1), 64'd0);
        chk("midrst_in_ready", 64'(in_ready1), 64'd1);
        chk("midrst_out_valid2", 64'(out_valid2), 64'd0);
        chk("midrst_imm", imm1, 64'd0);
        chk("midrst_cnt", 64'(cnt1), 64'd0);
        q1.delete();
        q2.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, vt[11], 1'b1, acc);
        chk("postrst_accept", 64'(acc), 64'd1);
        chk("postrst_latency", 64'(out_valid1), 64'd1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
